// File: rtl/platform_nios_cpu_mul_combine.sv
// Folds the three 16x16 partial products into the low 32 bits of a 32x32 product.
// Latency: 2 edges from M-stage presentation to W_* (A_en=W_en=1), one multiply per cycle.
// Backpressure: A_en/W_en stall their stage; A_en with W_en low over a valid A entry sets mul_ovf_err.
module platform_nios_cpu_mul_combine #(
    parameter int DST_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      M_mul_cell_p1,
    input  logic [31:0]      M_mul_cell_p2,
    input  logic [31:0]      M_mul_cell_p3,
    input  logic             M_mul_valid,
    input  logic [DST_W-1:0] M_dst_regnum,
    input  logic             M_flush,
    input  logic             A_en,
    input  logic             A_flush,
    input  logic             W_en,
    output logic             A_mul_busy,
    output logic [31:0]      W_mul_result,
    output logic             W_mul_valid,
    output logic [DST_W-1:0] W_mul_dst_regnum,
    output logic             mul_ovf_err
);

    logic [31:0]      a_p1;
    logic [15:0]      a_cross;
    logic             a_valid;
    logic [DST_W-1:0] a_dst;

    logic [15:0]      m_cross;
    logic [31:0]      a_sum;

    // Upper halves of the cross products sit entirely above bit 31, so only
    // their low 16 bits contribute to the result.
    assign m_cross = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
    assign a_sum   = a_p1 + {a_cross, 16'h0000};

    assign A_mul_busy = a_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_p1             <= '0;
            a_cross          <= '0;
            a_valid          <= 1'b0;
            a_dst            <= '0;
            W_mul_result     <= '0;
            W_mul_valid      <= 1'b0;
            W_mul_dst_regnum <= '0;
            mul_ovf_err      <= 1'b0;
        end else begin
            if (A_en) begin
                a_p1    <= M_mul_cell_p1;
                a_cross <= m_cross;
                a_valid <= M_mul_valid & ~M_flush;
                a_dst   <= M_dst_regnum;
            end
            if (W_en) begin
                W_mul_result     <= a_sum;
                W_mul_valid      <= a_valid & ~A_flush;
                W_mul_dst_regnum <= a_dst;
            end
            // A valid A entry replaced without moving to W is lost for good.
            if (A_en && !W_en && a_valid) begin
                mul_ovf_err <= 1'b1;
            end
        end
    end

endmodule
